// File: rtl/avalon_burst_reader.sv
// avalon_burst_reader: splits a (start address, word count) command into
// Avalon-MM read bursts of at most MAX_BURST words, buffers the returned
// words in a first-word-fall-through FIFO and streams them out with a
// last-word marker and a completion pulse. One burst is in flight at a time,
// and a burst is only requested when the FIFO can hold all of it.
// Optional build macro AVALON_BURST_READER_STATS_EN adds the stat_bursts and
// stat_wait saturating counters.
module avalon_burst_reader #(
  parameter int DATA_W       = 32,
  parameter int BURSTCOUNT_W = 4,
  parameter int LEN_W        = 12,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [31:0]             cmd_addr,
  input  logic [LEN_W-1:0]        cmd_len,
  output logic [31:0]             avm_address,
  output logic                    avm_read,
  output logic [BURSTCOUNT_W-1:0] avm_burstcount,
  input  logic                    avm_waitrequest,
  input  logic [DATA_W-1:0]       avm_readdata,
  input  logic                    avm_readdatavalid,
  output logic                    st_valid,
  input  logic                    st_ready,
  output logic [DATA_W-1:0]       st_data,
  output logic                    st_last,
  output logic                    done
`ifdef AVALON_BURST_READER_STATS_EN
  ,
  output logic [15:0]             stat_bursts,
  output logic [15:0]             stat_wait
`endif
);

  localparam int MAX_BURST = 2 ** (BURSTCOUNT_W - 1);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CW        = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DRAIN} state_t;

  state_t                  r_state;
  logic [31:0]             r_cur_addr;
  logic [LEN_W-1:0]        r_remaining;
  logic [LEN_W-1:0]        r_out_left;
  logic [BURSTCOUNT_W-1:0] r_beats;

  logic [DATA_W-1:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wptr;
  logic [AW-1:0]           r_rptr;
  logic [CW-1:0]           r_count;

  logic                    w_empty;
  logic                    w_full;
  logic [CW-1:0]           w_free;
  logic [BURSTCOUNT_W-1:0] w_b;
  logic                    w_space_ok;
  logic                    w_beat;
  logic                    w_push;
  logic                    w_pop;

  // Burst size for a given number of outstanding words: min(len, MAX_BURST).
  function automatic logic [BURSTCOUNT_W-1:0] burst_of(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(MAX_BURST)) return BURSTCOUNT_W'(MAX_BURST);
    else return len[BURSTCOUNT_W-1:0];
  endfunction

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_free     = CW'(FIFO_DEPTH) - r_count;
  assign w_b        = burst_of(r_remaining);
  assign w_space_ok = (w_free >= CW'(w_b));
  // Beats only count while a burst is owed; stray or post-reset beats are ignored.
  assign w_beat     = (r_state == WAIT_DATA) && (r_beats != '0) && avm_readdatavalid;
  assign w_push     = w_beat && !w_full;
  assign w_pop      = !w_empty && st_ready;

  assign st_valid   = !w_empty;
  assign st_data    = r_mem[r_rptr];
  assign st_last    = !w_empty && (r_out_left == LEN_W'(1));

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= avm_readdata;
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Command sequencing FSM with registered Avalon request and handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      cmd_ready      <= 1'b1;
      avm_read       <= 1'b0;
      avm_address    <= '0;
      avm_burstcount <= '0;
      done           <= 1'b0;
      r_cur_addr     <= '0;
      r_remaining    <= '0;
      r_out_left     <= '0;
      r_beats        <= '0;
    end else begin
      done <= 1'b0;
      if (w_pop) r_out_left <= r_out_left - LEN_W'(1);
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready   <= 1'b0;
            r_cur_addr  <= {cmd_addr[31:2], 2'b00};
            r_remaining <= cmd_len;
            r_out_left  <= cmd_len;
            if (cmd_len == '0) begin
              r_state <= DRAIN;
            end else begin
              // FIFO is always empty in IDLE, so the first request goes out at once.
              r_state        <= ISSUE;
              avm_read       <= 1'b1;
              avm_address    <= {cmd_addr[31:2], 2'b00};
              avm_burstcount <= burst_of(cmd_len);
            end
          end
        end
        ISSUE: begin
          if (avm_read) begin
            if (!avm_waitrequest) begin
              avm_read    <= 1'b0;
              r_cur_addr  <= r_cur_addr + (32'(w_b) << 2);
              r_remaining <= r_remaining - LEN_W'(w_b);
              r_beats     <= w_b;
              r_state     <= WAIT_DATA;
            end
          end else if (w_space_ok) begin
            avm_read       <= 1'b1;
            avm_address    <= r_cur_addr;
            avm_burstcount <= w_b;
          end
        end
        WAIT_DATA: begin
          if (r_beats == '0) r_state <= (r_remaining != '0) ? ISSUE : DRAIN;
          else if (w_beat)   r_beats <= r_beats - BURSTCOUNT_W'(1);
        end
        DRAIN: begin
          if (w_empty && (r_out_left == '0)) begin
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef AVALON_BURST_READER_STATS_EN
  // Saturating counters of accepted bursts and stalled request cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_bursts <= '0;
      stat_wait   <= '0;
    end else begin
      if (avm_read && !avm_waitrequest && (stat_bursts != 16'hFFFF)) stat_bursts <= stat_bursts + 16'd1;
      if (avm_read && avm_waitrequest && (stat_wait != 16'hFFFF))    stat_wait   <= stat_wait + 16'd1;
    end
  end
`endif

endmodule
